// File: rtl/vga_pkg.sv
// Shared types and helpers for the mode-sequencing VGA timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int COORD_W = 10;

    function automatic int line_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Pixel-enable divider, h/v counters and registered sync/active/coordinate decode.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               clear,
    input  logic               half_x,
    output logic               pix_ce,
    output logic               frame_end,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               mode
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int DW      = cnt_width(CLK_DIV);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          h_last;
    logic          v_last;
    logic          visible;
    logic          in_hs;
    logic          in_vs;

    assign pix_ce    = run && (div_cnt == DIV_LAST);
    assign h_last    = (hcount == H_LAST);
    assign v_last    = (vcount == V_LAST);
    assign frame_end = pix_ce && h_last && v_last;

    // Counters sit at zero whenever the sequencer is not running a mode.
    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            div_cnt <= '0;
            hcount  <= '0;
            vcount  <= '0;
        end else begin
            div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
            if (pix_ce) begin
                if (h_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

    assign visible = run && (hcount < H_VIS) && (vcount < V_VIS);
    assign in_hs   = run && (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    assign in_vs   = run && (vcount >= VS_FIRST) && (vcount <= VS_LAST);

    // One register stage for every decoded output, mode included, keeps them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync  <= ~SYNC_ACT;
            vsync  <= ~SYNC_ACT;
            active <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
            mode   <= 1'b0;
        end else begin
            hsync  <= in_hs ? SYNC_ACT : ~SYNC_ACT;
            vsync  <= in_vs ? SYNC_ACT : ~SYNC_ACT;
            active <= visible;
            if (visible) begin
                pix_x <= half_x ? COORD_W'(hcount >> 1) : COORD_W'(hcount);
                pix_y <= COORD_W'(vcount);
            end else begin
                pix_x <= '0;
                pix_y <= '0;
            end
            mode   <= half_x;
        end
    end

endmodule

// File: rtl/vga_mode_seq.sv
// Sequencer: FRAMES_PER_MODE frames at full width, then the same at half width, then DONE.
module vga_mode_seq
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE        = 640,
    parameter int   H_FP            = 16,
    parameter int   H_SYNC          = 96,
    parameter int   H_BP            = 48,
    parameter int   V_ACTIVE        = 480,
    parameter int   V_FP            = 10,
    parameter int   V_SYNC          = 2,
    parameter int   V_BP            = 33,
    parameter int   CLK_DIV         = 2,
    parameter int   FRAMES_PER_MODE = 1,
    parameter logic SYNC_ACT        = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               mode,
    output logic               done_a,
    output logic               done
);

    localparam int            FW     = cnt_width(FRAMES_PER_MODE);
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_MODE - 1);

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_next;
    logic          done_a_next;
    logic          done_next;
    logic          clear;
    logic          run;
    logic          half_x;
    logic          frame_end;

    assign run    = (state == RUN_A) || (state == RUN_B);
    assign half_x = (state == RUN_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            done_a    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_cnt_next;
            done_a    <= done_a_next;
            done      <= done_next;
        end
    end

    // start is only honoured while stopped; during RUN_A/RUN_B it is dropped.
    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        done_a_next    = done_a;
        done_next      = done;
        clear          = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = RUN_A;
                    frame_cnt_next = '0;
                    done_a_next    = 1'b0;
                    done_next      = 1'b0;
                    clear          = 1'b1;
                end
            end
            RUN_A: begin
                if (frame_end) begin
                    if (frame_cnt == F_LAST) begin
                        state_next     = RUN_B;
                        frame_cnt_next = '0;
                        done_a_next    = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt + 1'b1;
                    end
                end
            end
            RUN_B: begin
                if (frame_end) begin
                    if (frame_cnt == F_LAST) begin
                        state_next     = DONE;
                        frame_cnt_next = '0;
                        done_next      = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV),
        .SYNC_ACT (SYNC_ACT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .half_x    (half_x),
        .pix_ce    (pix_ce),
        .frame_end (frame_end),
        .hsync     (hsync),
        .vsync     (vsync),
        .active    (active),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .mode      (mode)
    );

endmodule

// File: tb/tb_vga_mode_seq.sv
// Directed bench on a reduced 14x7 raster: CLK_DIV=2/FPM=1 main DUT, CLK_DIV=1/FPM=3 second DUT.
module tb_vga_mode_seq;

    localparam int HT        = 14;
    localparam int FRAME_PIX = 98;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start3;
    logic       pix_ce, hsync, vsync, active, mode, done_a, done;
    logic [9:0] pix_x, pix_y;
    logic       pix_ce3, hsync3, vsync3, active3, mode3, done_a3, done3;
    logic [9:0] pix_x3, pix_y3;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         k        = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    vga_mode_seq #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .FRAMES_PER_MODE(1), .SYNC_ACT(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .pix_ce(pix_ce),
        .hsync(hsync), .vsync(vsync), .active(active),
        .pix_x(pix_x), .pix_y(pix_y), .mode(mode),
        .done_a(done_a), .done(done)
    );

    vga_mode_seq #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .FRAMES_PER_MODE(3), .SYNC_ACT(1'b0)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .pix_ce(pix_ce3),
        .hsync(hsync3), .vsync(vsync3), .active(active3),
        .pix_x(pix_x3), .pix_y(pix_y3), .mode(mode3),
        .done_a(done_a3), .done(done3)
    );

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        step(); step();
        n_checks++; if (hsync !== 1'b1) $display("FAIL reset_hsync got=%b exp=1", hsync); else n_pass++;
        n_checks++; if (vsync !== 1'b1) $display("FAIL reset_vsync got=%b exp=1", vsync); else n_pass++;
        n_checks++; if (active !== 1'b0) $display("FAIL reset_active got=%b exp=0", active); else n_pass++;
        n_checks++; if (pix_x !== 10'd0) $display("FAIL reset_pix_x got=%0d exp=0", pix_x); else n_pass++;
        n_checks++; if (pix_y !== 10'd0) $display("FAIL reset_pix_y got=%0d exp=0", pix_y); else n_pass++;
        n_checks++; if (mode !== 1'b0) $display("FAIL reset_mode got=%b exp=0", mode); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done_a got=%b exp=0", done_a); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL reset_pix_ce got=%b exp=0", pix_ce); else n_pass++;
        n_checks++; if (pix_ce3 !== 1'b0) $display("FAIL reset_pix_ce3 got=%b exp=0", pix_ce3); else n_pass++;
        rst = 1'b0;
        step(); step(); step();
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL idle_pix_ce got=%b exp=0", pix_ce); else n_pass++;
        n_checks++; if (hsync !== 1'b1) $display("FAIL idle_hsync got=%b exp=1", hsync); else n_pass++;
        n_checks++; if (active !== 1'b0) $display("FAIL idle_active got=%b exp=0", active); else n_pass++;
    endtask

    task automatic test_start_rst_same();
        start = 1'b1; rst = 1'b1;
        step();
        start = 1'b0; rst = 1'b0;
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL startrst_pix_ce0 got=%b exp=0", pix_ce); else n_pass++;
        step();
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL startrst_pix_ce1 got=%b exp=0", pix_ce); else n_pass++;
        n_checks++; if (active !== 1'b0) $display("FAIL startrst_active got=%b exp=0", active); else n_pass++;
    endtask

    // Full A+B sequence, every output compared each clk against the raster arithmetic.
    task automatic test_two_frames();
        int         p, h, v, hs_low, vs_low, first_hs;
        logic       e_act, e_hs, e_vs, e_ce, e_mode, e_da, e_d;
        logic [9:0] e_x, e_y, want;
        hs_low = 0; vs_low = 0; first_hs = 0;
        for (int j = 0; j < 8; j++) exp_q.push_back(10'(j / 2));
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL first_pix_ce_k0 got=%b exp=0", pix_ce); else n_pass++;
        for (int i = 1; i <= 392; i++) begin
            step();
            p      = ((k - 1) / 2) % FRAME_PIX;
            h      = p % HT;
            v      = p / HT;
            e_mode = (k >= 197);
            e_act  = (h < 8) && (v < 4);
            e_hs   = !((h == 10) || (h == 11));
            e_vs   = (v != 5);
            e_x    = e_act ? 10'(e_mode ? h / 2 : h) : 10'd0;
            e_y    = e_act ? 10'(v) : 10'd0;
            e_ce   = (k % 2 == 1) && (k <= 391);
            e_da   = (k >= 196);
            e_d    = (k >= 392);
            n_checks++; if (hsync !== e_hs) $display("FAIL seq_hsync k=%0d got=%b exp=%b", k, hsync, e_hs); else n_pass++;
            n_checks++; if (vsync !== e_vs) $display("FAIL seq_vsync k=%0d got=%b exp=%b", k, vsync, e_vs); else n_pass++;
            n_checks++; if (active !== e_act) $display("FAIL seq_active k=%0d got=%b exp=%b", k, active, e_act); else n_pass++;
            n_checks++; if (pix_x !== e_x) $display("FAIL seq_pix_x k=%0d got=%0d exp=%0d", k, pix_x, e_x); else n_pass++;
            n_checks++; if (pix_y !== e_y) $display("FAIL seq_pix_y k=%0d got=%0d exp=%0d", k, pix_y, e_y); else n_pass++;
            n_checks++; if (pix_ce !== e_ce) $display("FAIL seq_pix_ce k=%0d got=%b exp=%b", k, pix_ce, e_ce); else n_pass++;
            n_checks++; if (mode !== e_mode) $display("FAIL seq_mode k=%0d got=%b exp=%b", k, mode, e_mode); else n_pass++;
            n_checks++; if (done_a !== e_da) $display("FAIL seq_done_a k=%0d got=%b exp=%b", k, done_a, e_da); else n_pass++;
            n_checks++; if (done !== e_d) $display("FAIL seq_done k=%0d got=%b exp=%b", k, done, e_d); else n_pass++;
            if (k <= 28 && hsync === 1'b0) hs_low++;
            if (first_hs == 0 && hsync === 1'b0) first_hs = k;
            if (k <= 196 && vsync === 1'b0) vs_low++;
            if (k >= 197 && k <= 211 && (k % 2 == 1) && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_checks++; if (pix_x !== want) $display("FAIL sb_half_x k=%0d got=%0d exp=%0d", k, pix_x, want); else n_pass++;
            end
        end
        n_checks++; if (hs_low != 4) $display("FAIL hsync_width got=%0d exp=4", hs_low); else n_pass++;
        n_checks++; if (first_hs != 21) $display("FAIL hsync_first got=%0d exp=21", first_hs); else n_pass++;
        n_checks++; if (vs_low != 28) $display("FAIL vsync_width got=%0d exp=28", vs_low); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
        repeat (4) step();
        n_checks++; if (hsync !== 1'b1) $display("FAIL done_hsync got=%b exp=1", hsync); else n_pass++;
        n_checks++; if (vsync !== 1'b1) $display("FAIL done_vsync got=%b exp=1", vsync); else n_pass++;
        n_checks++; if (active !== 1'b0) $display("FAIL done_active got=%b exp=0", active); else n_pass++;
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL done_pix_ce got=%b exp=0", pix_ce); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL done_sticky got=%b exp=1", done); else n_pass++;
        n_checks++; if (done_a !== 1'b1) $display("FAIL done_a_sticky got=%b exp=1", done_a); else n_pass++;
    endtask

    task automatic test_restart_rst_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        n_checks++; if (done !== 1'b0) $display("FAIL restart_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL restart_done_a got=%b exp=0", done_a); else n_pass++;
        step();
        n_checks++; if (pix_ce !== 1'b1) $display("FAIL restart_pix_ce got=%b exp=1", pix_ce); else n_pass++;
        n_checks++; if (active !== 1'b1) $display("FAIL restart_active got=%b exp=1", active); else n_pass++;
        while (k < 240) step();
        n_checks++; if (mode !== 1'b1) $display("FAIL midb_mode got=%b exp=1", mode); else n_pass++;
        n_checks++; if (pix_x !== 10'd3) $display("FAIL midb_pix_x got=%0d exp=3", pix_x); else n_pass++;
        n_checks++; if (pix_y !== 10'd1) $display("FAIL midb_pix_y got=%0d exp=1", pix_y); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (hsync !== 1'b1) $display("FAIL rstmid_hsync got=%b exp=1", hsync); else n_pass++;
        n_checks++; if (vsync !== 1'b1) $display("FAIL rstmid_vsync got=%b exp=1", vsync); else n_pass++;
        n_checks++; if (active !== 1'b0) $display("FAIL rstmid_active got=%b exp=0", active); else n_pass++;
        n_checks++; if (pix_x !== 10'd0) $display("FAIL rstmid_pix_x got=%0d exp=0", pix_x); else n_pass++;
        n_checks++; if (pix_y !== 10'd0) $display("FAIL rstmid_pix_y got=%0d exp=0", pix_y); else n_pass++;
        n_checks++; if (mode !== 1'b0) $display("FAIL rstmid_mode got=%b exp=0", mode); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL rstmid_done_a got=%b exp=0", done_a); else n_pass++;
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL rstmid_pix_ce got=%b exp=0", pix_ce); else n_pass++;
        step();
        n_checks++; if (pix_ce !== 1'b0) $display("FAIL rstmid_idle_ce got=%b exp=0", pix_ce); else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        step();
        n_checks++; if (pix_x !== 10'd0) $display("FAIL replay_pix_x0 got=%0d exp=0", pix_x); else n_pass++;
        n_checks++; if (pix_y !== 10'd0) $display("FAIL replay_pix_y0 got=%0d exp=0", pix_y); else n_pass++;
        n_checks++; if (mode !== 1'b0) $display("FAIL replay_mode got=%b exp=0", mode); else n_pass++;
        step(); step();
        n_checks++; if (pix_x !== 10'd1) $display("FAIL replay_pix_x1 got=%0d exp=1", pix_x); else n_pass++;
        while (k < 21) step();
        n_checks++; if (hsync !== 1'b0) $display("FAIL replay_hsync got=%b exp=0", hsync); else n_pass++;
    endtask

    task automatic test_fpm3_ignore_start();
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        k = 0;
        n_checks++; if (pix_ce3 !== 1'b1) $display("FAIL f3_pix_ce_k0 got=%b exp=1", pix_ce3); else n_pass++;
        while (k < 296) begin
            step();
            start3 = (k == 50 || k == 150);
            if (k == 100) begin
                n_checks++; if (pix_x3 !== 10'd1) $display("FAIL f3_pix_x_k100 got=%0d exp=1", pix_x3); else n_pass++;
                n_checks++; if (active3 !== 1'b1) $display("FAIL f3_active_k100 got=%b exp=1", active3); else n_pass++;
            end
            if (k == 200) begin
                n_checks++; if (pix_ce3 !== 1'b1) $display("FAIL f3_pix_ce_k200 got=%b exp=1", pix_ce3); else n_pass++;
            end
            if (k == 293) begin
                n_checks++; if (done_a3 !== 1'b0) $display("FAIL f3_done_a_early got=%b exp=0", done_a3); else n_pass++;
            end
            if (k == 294) begin
                n_checks++; if (done_a3 !== 1'b1) $display("FAIL f3_done_a got=%b exp=1", done_a3); else n_pass++;
                n_checks++; if (mode3 !== 1'b0) $display("FAIL f3_mode_k294 got=%b exp=0", mode3); else n_pass++;
            end
            if (k == 295) begin
                n_checks++; if (mode3 !== 1'b1) $display("FAIL f3_mode_k295 got=%b exp=1", mode3); else n_pass++;
            end
        end
        start3 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        test_reset();
        test_start_rst_same();
        test_two_frames();
        test_restart_rst_mid();
        test_fpm3_ignore_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
